ham_decode_arb: RTL and testbench



---
 rtl/ham_decode_arb.sv | 165 ++++++++++++++++
 tb/tb_ham_decode_arb.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ham_decode_arb.sv
// ham_decode_arb: round-robin arbiter for two codeword sources feeding one
// shared Hamming(7,4) syndrome/correction stage, with a held result and a
// saturating count of corrected-error events.
// Optional build macro: HAM_DATA_INV_EN drives out_data active-low
// (inverted corrected data, reset value 4'b1111).
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. Sources must hold valid and code until they see ready.
// a_ready/b_ready are combinational from state, valids and last_grant, and
// are high only in IDLE. out_valid stays high, with out_* stable, until
// out_ready is seen high.
module ham_decode_arb #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a_valid,
   input  logic [6:0]       a_code,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [6:0]       b_code,
   output logic             b_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_src,
   output logic [3:0]       out_data,
   output logic [2:0]       out_syndrome,
   output logic [CNT_W-1:0] err_count,
   input  logic             err_clr,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      HOLD   = 2'd2
   } state_t;

`ifdef HAM_DATA_INV_EN
   localparam logic [3:0] DATA_RST = 4'b1111;
`else
   localparam logic [3:0] DATA_RST = 4'b0000;
`endif

   state_t           state_q, state_d;
   logic [6:0]       code_q, code_d;
   logic             src_q, src_d;
   logic             last_grant_q, last_grant_d;   // 0 = A, 1 = B
   logic             out_valid_q, out_valid_d;
   logic             out_src_q, out_src_d;
   logic [3:0]       out_data_q, out_data_d;
   logic [2:0]       out_syndrome_q, out_syndrome_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;

   logic             grant_a, grant_b;
   logic [2:0]       syn;
   logic [6:0]       flip_mask;
   logic [6:0]       fixed;
   logic [3:0]       data_true;

   // Syndrome and single-bit correction of the captured codeword.
   always_comb begin
      syn[2] = code_q[3] ^ code_q[4] ^ code_q[5] ^ code_q[6];
      syn[1] = code_q[1] ^ code_q[2] ^ code_q[5] ^ code_q[6];
      syn[0] = code_q[0] ^ code_q[2] ^ code_q[4] ^ code_q[6];
      flip_mask = 7'b0;
      if (syn != 3'd0) begin
         flip_mask[syn - 3'd1] = 1'b1;
      end
      fixed     = code_q ^ flip_mask;
      data_true = {fixed[6], fixed[5], fixed[4], fixed[2]};
   end

   // Round-robin choice: on contention the source not granted last time wins.
   always_comb begin
      grant_a = a_valid && (!b_valid || last_grant_q);
      grant_b = b_valid && !grant_a;
   end

   // Next-state, capture, decode-register and counter logic.
   always_comb begin
      state_d        = state_q;
      code_d         = code_q;
      src_d          = src_q;
      last_grant_d   = last_grant_q;
      out_valid_d    = out_valid_q;
      out_src_d      = out_src_q;
      out_data_d     = out_data_q;
      out_syndrome_d = out_syndrome_q;
      err_count_d    = err_count_q;
      a_ready        = 1'b0;
      b_ready        = 1'b0;
      case (state_q)
         IDLE: begin
            // Readies are masked while reset is asserted.
            a_ready = grant_a && rst_n;
            b_ready = grant_b && rst_n;
            if (grant_a || grant_b) begin
               code_d       = grant_a ? a_code : b_code;
               src_d        = grant_b;
               last_grant_d = grant_b;
               state_d      = DECODE;
            end
         end
         DECODE: begin
`ifdef HAM_DATA_INV_EN
            out_data_d = ~data_true;
`else
            out_data_d = data_true;
`endif
            out_syndrome_d = syn;
            out_src_d      = src_q;
            out_valid_d    = 1'b1;
            state_d        = HOLD;
            if ((syn != 3'd0) && (err_count_q != {CNT_W{1'b1}})) begin
               err_count_d = err_count_q + CNT_W'(1);
            end
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A clear beats a same-cycle increment.
      if (err_clr) begin
         err_count_d = '0;
      end
   end

   // State and datapath registers, asynchronously reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         code_q         <= 7'd0;
         src_q          <= 1'b0;
         last_grant_q   <= 1'b1;
         out_valid_q    <= 1'b0;
         out_src_q      <= 1'b0;
         out_data_q     <= DATA_RST;
         out_syndrome_q <= 3'd0;
         err_count_q    <= '0;
      end else begin
         state_q        <= state_d;
         code_q         <= code_d;
         src_q          <= src_d;
         last_grant_q   <= last_grant_d;
         out_valid_q    <= out_valid_d;
         out_src_q      <= out_src_d;
         out_data_q     <= out_data_d;
         out_syndrome_q <= out_syndrome_d;
         err_count_q    <= err_count_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_src      = out_src_q;
   assign out_data     = out_data_q;
   assign out_syndrome = out_syndrome_q;
   assign err_count    = err_count_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_ham_decode_arb.sv
// Directed-vector bench for ham_decode_arb (counter width 2 so saturation is
// reachable quickly). Inputs change and outputs are sampled around the
// falling clock edge.
module tb_ham_decode_arb;
   localparam int CNT_W = 2;

   logic             clk, rst_n;
   logic             a_valid, b_valid, a_ready, b_ready;
   logic [6:0]       a_code, b_code;
   logic             out_valid, out_ready, out_src, err_clr;
   logic [3:0]       out_data;
   logic [2:0]       out_syndrome;
   logic [CNT_W-1:0] err_count;
   logic [1:0]       dbg_state;

   int n_cmp = 0;
   int n_fail = 0;

`ifdef HAM_DATA_INV_EN
   localparam logic [3:0] DATA_RST = 4'b1111;
`else
   localparam logic [3:0] DATA_RST = 4'b0000;
`endif

   ham_decode_arb #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_code(a_code), .a_ready(a_ready),
      .b_valid(b_valid), .b_code(b_code), .b_ready(b_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
      .out_data(out_data), .out_syndrome(out_syndrome),
      .err_count(err_count), .err_clr(err_clr), .dbg_state(dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected output polarity for a true-polarity corrected nibble.
   function automatic logic [3:0] pol(input logic [3:0] d);
`ifdef HAM_DATA_INV_EN
      return ~d;
`else
      return d;
`endif
   endfunction

   task automatic do_reset();
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   // One full transaction with out_ready high; ends at an IDLE falling edge.
   task automatic send(input logic src, input logic [6:0] code, input logic [3:0] exp_d,
                       input logic [2:0] exp_s, input logic [CNT_W-1:0] exp_c, input string nm);
      @(negedge clk);
      out_ready = 1'b1;
      if (src) begin b_valid = 1'b1; b_code = code; end
      else begin a_valid = 1'b1; a_code = code; end
      #1;
      n_cmp++; if ({a_ready, b_ready} !== {~src, src}) begin n_fail++; $display("FAIL %s_grant: a/b_ready=%b%b want %b%b", nm, a_ready, b_ready, ~src, src); end
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      #1;
      n_cmp++; if ({out_valid, a_ready, b_ready} !== 3'b000) begin n_fail++; $display("FAIL %s_decode: valid/ready=%b want 000", nm, {out_valid, a_ready, b_ready}); end
      @(negedge clk);
      n_cmp++; if ({out_valid, out_src, out_data, out_syndrome} !== {1'b1, src, exp_d, exp_s}) begin n_fail++;
         $display("FAIL %s_result: v=%b src=%b d=%b s=%b want v=1 src=%b d=%b s=%b", nm, out_valid, out_src, out_data, out_syndrome, src, exp_d, exp_s); end
      n_cmp++; if (err_count !== exp_c) begin n_fail++; $display("FAIL %s_errcnt: got %0d want %0d", nm, err_count, exp_c); end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_release: out_valid=%b want 0", nm, out_valid); end
   endtask

   task automatic test_reset();
      #3;
      a_valid = 1'b1;
      #1;
      n_cmp++; if ({a_ready, b_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b%b want 00", a_ready, b_ready); end
      n_cmp++; if ({out_valid, out_src, out_data, out_syndrome, err_count, dbg_state} !== {1'b0, 1'b0, DATA_RST, 3'd0, 2'd0, 2'd0}) begin n_fail++;
         $display("FAIL reset_vals: v=%b src=%b d=%b s=%b c=%0d st=%0d", out_valid, out_src, out_data, out_syndrome, err_count, dbg_state); end
      a_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_clean_and_errors();
      send(1'b0, 7'h55, pol(4'b1011), 3'b000, 2'd0, "clean_a");
      send(1'b1, 7'h75, pol(4'b1011), 3'b110, 2'd1, "err_e5_b");
      send(1'b0, 7'h01, pol(4'b0000), 3'b001, 2'd2, "err_e0_a");
   endtask

   task automatic test_contention();
      do_reset();
      out_ready = 1'b1;
      a_valid = 1'b1; a_code = 7'h55;
      b_valid = 1'b1; b_code = 7'h75;
      for (int t = 0; t < 4; t++) begin
         #1;
         n_cmp++; if ({a_ready, b_ready} !== ((t % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL contend_grant%0d: a/b_ready=%b%b", t, a_ready, b_ready); end
         @(negedge clk); #1;
         n_cmp++; if ({a_ready, b_ready} !== 2'b00) begin n_fail++; $display("FAIL contend_decode%0d: a/b_ready=%b%b want 00", t, a_ready, b_ready); end
         @(negedge clk); #1;
         n_cmp++; if ({out_valid, out_src, a_ready, b_ready} !== {1'b1, (t % 2 == 1), 2'b00}) begin n_fail++;
            $display("FAIL contend_hold%0d: v=%b src=%b rdy=%b%b want src=%0d", t, out_valid, out_src, a_ready, b_ready, t % 2); end
         @(negedge clk);
      end
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      a_valid = 1'b1; a_code = 7'h55;
      #1;
      n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL bp_grant: a_ready=%b want 1", a_ready); end
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++; if ({out_valid, out_data, out_syndrome, out_src, a_ready} !== {1'b1, pol(4'b1011), 3'b000, 1'b0, 1'b0}) begin n_fail++;
            $display("FAIL bp_hold%0d: v=%b d=%b s=%b src=%b a_ready=%b", i, out_valid, out_data, out_syndrome, out_src, a_ready); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk); #1;
      n_cmp++; if ({out_valid, a_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release: v=%b a_ready=%b want v=0 a_ready=1", out_valid, a_ready); end
      a_valid = 1'b0;
      #1;
      n_cmp++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL drop_ready: a_ready=%b want 0", a_ready); end
      @(negedge clk);
      n_cmp++; if ({dbg_state, out_valid} !== {2'd0, 1'b0}) begin n_fail++; $display("FAIL drop_nocapture: st=%0d v=%b want 0/0", dbg_state, out_valid); end
   endtask

   task automatic test_saturation_clear();
      err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      n_cmp++; if (err_count !== 2'd0) begin n_fail++; $display("FAIL clr_idle: got %0d want 0", err_count); end
      for (int i = 0; i < 5; i++) begin
         send(1'b0, 7'h01, pol(4'b0000), 3'b001, (i < 3) ? 2'(i + 1) : 2'd3, "sat");
      end
      err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      send(1'b1, 7'h75, pol(4'b1011), 3'b110, 2'd1, "pre_clr");
      out_ready = 1'b1;
      a_valid = 1'b1; a_code = 7'h01;
      @(negedge clk);
      a_valid = 1'b0; err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      n_cmp++; if ({out_valid, out_syndrome, err_count} !== {1'b1, 3'b001, 2'd0}) begin n_fail++;
         $display("FAIL clr_decode: v=%b s=%b cnt=%0d want v=1 s=001 cnt=0", out_valid, out_syndrome, err_count); end
      @(negedge clk);
   endtask

   task automatic test_reset_midop();
      send(1'b1, 7'h75, pol(4'b1011), 3'b110, 2'd1, "pre_rst");
      a_valid = 1'b1; a_code = 7'h01;
      @(negedge clk);
      #1;
      n_cmp++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL rst_in_decode: st=%0d want 1", dbg_state); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if ({out_valid, out_src, out_data, out_syndrome, err_count, dbg_state} !== {1'b0, 1'b0, DATA_RST, 3'd0, 2'd0, 2'd0}) begin n_fail++;
         $display("FAIL rst_async: v=%b src=%b d=%b s=%b c=%0d st=%0d", out_valid, out_src, out_data, out_syndrome, err_count, dbg_state); end
      n_cmp++; if ({a_ready, b_ready} !== 2'b00) begin n_fail++; $display("FAIL rst_ready: got %b%b want 00", a_ready, b_ready); end
      a_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_after%0d: out_valid=%b want 0", i, out_valid); end
      end
   endtask

   initial begin
      rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_code = 7'd0; b_code = 7'd0;
      out_ready = 1'b0; err_clr = 1'b0;
      test_reset();
      test_clean_and_errors();
      test_contention();
      test_backpressure();
      test_saturation_clear();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
